pc_ir: RTL
==========

# pc_ir

Program-counter and instruction-register stage feeding the CPU control unit. Holds the PC and the IR, forms the memory address from either the PC or register-file bus A, and applies the control unit's PC-select command: hold, increment, relative branch or register jump. Sits between instruction memory and the control unit. Also keeps a retired-fetch counter and the address of the instruction currently held in the IR, for debug.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst_n` input, 1: synchronous, active-low reset.
- `ps_in` input, 2: PC select from the control unit. 00 hold, 01 increment, 10 branch, 11 jump.
- `il_in` input, 1: instruction load; IR captures `mem_rdata_in`.
- `mm_in` input, 1: memory address mux. 1 selects the PC; 0 selects `reg_a_in`.
- `mem_rdata_in` input, 16: memory read data.
- `reg_a_in` input, 16: register-file bus A, used as the jump target and data address.
- `addr_out` output, 16: memory address.
- `ins_out` output, 16: IR contents, to the control unit.
- `pc_out` output, 16: current PC.
- `ins_pc_out` output, 16: PC value at which the current IR contents were fetched.
- `fetch_cnt_out` output, 16: number of IR loads since reset.

## Operation
- Registers: `pc_r`, `ir_r`, `ins_pc_r`, `cnt_r`.
- Reset (`rst_n`=0 at a rising edge) overrides all other inputs, including one asserted mid-instruction:
  - `pc_r`=RESET_PC
  - `ir_r`=16'h0000
  - `ins_pc_r`=RESET_PC
  - `cnt_r`=0
- PC update, evaluated every non-reset edge (all arithmetic modulo 2^16, no carry out):
  - 00: `pc_r` unchanged.
  - 01: `pc_r` <= `pc_r` + 1. 16'hFFFF wraps to 16'h0000.
  - 10: `pc_r` <= `pc_r` + sext(off6).
    - off6 = {`ir_r`[8:6], `ir_r`[2:0]}, a 6-bit two's complement value sign-extended from bit 5. Range -32..+31.
    - The offset is relative to the branch instruction's own address, because the PC has not been incremented during fetch.
  - 11: `pc_r` <= `reg_a_in`.
- Taken/not-taken is resolved by the control unit, which drives 10 or 01. This block does no flag evaluation.
- IR load:
  - When `il_in`=1: `ir_r` <= `mem_rdata_in`, `ins_pc_r` <= `pc_r` (the pre-update value), `cnt_r` <= `cnt_r` + 1. The counter wraps at 16'hFFFF to 0.
  - When `il_in`=0: all three registers hold.
- Simultaneous `il_in`=1 and `ps_in`≠00 is legal and not produced by the control unit:
  - Both updates occur.
  - The branch offset uses the old `ir_r`.
  - `ins_pc_r` captures the old `pc_r`.
- Address mux is combinational: `addr_out` = `mm_in` ? `pc_r` : `reg_a_in`.
- `ins_out`, `pc_out`, `ins_pc_out` and `fetch_cnt_out` drive registers directly, with no combinational path from inputs.

## Timing
- Fetch, 1 cycle: in control-unit state INF, `mm_in`=1, `il_in`=1, `ps_in`=00. At the next edge the IR holds the word at the PC address, and the PC is unchanged.
- Execute, 1 cycle: in EX0, `ps_in` is 01, 10 or 11. The new PC is visible one cycle after the edge. `ins_out` is stable throughout EX0.
- Memory read is combinational within the same cycle. `mem_rdata_in` must be valid before the edge on which `il_in`=1.
- Output values after reset:
  - `addr_out` = RESET_PC when `mm_in`=1.
  - `ins_out`=0, `pc_out`=RESET_PC, `ins_pc_out`=RESET_PC, `fetch_cnt_out`=0.
- Reset latency: outputs take their reset values at the first rising edge with `rst_n`=0. Normal operation resumes at the first edge with `rst_n`=1.
- Halt: the control unit drives `ps_in`=00 and `il_in`=0 indefinitely, and all registers hold.

## Test plan
- Reset and fetch:
  - Stimulus: RESET_PC=0, hold `rst_n`=0 for 2 cycles. Then `mm_in`=1, `il_in`=1, `mem_rdata_in`=16'h1234.
  - Response: during reset `addr_out`=0. After the fetch edge, `ins_out`=16'h1234, `ins_pc_out`=0, `pc_out`=0, `fetch_cnt_out`=1.
- Increment wrap:
  - Stimulus: jump to 16'hFFFF (`ps_in`=11, `reg_a_in`=16'hFFFF), then `ps_in`=01.
  - Response: `pc_out`=16'hFFFF, then 16'h0000.
- Branch both signs:
  - Stimulus A: `pc_r`=16'h0010, IR=16'b0000000_011_000_111 (off6=+31), `ps_in`=10. Response: `pc_out`=16'h002F.
  - Stimulus B: IR=16'b0000000_100_000_000 (off6=-32), `pc_r`=16'h0010, `ps_in`=10. Response: `pc_out`=16'hFFF0.
- Address mux:
  - Stimulus: `pc_r`=16'h0005, `reg_a_in`=16'h00A0; toggle `mm_in` 1 then 0.
  - Response: `addr_out` is 16'h0005 then 16'h00A0 within the same cycle. No register changes when `il_in`=0 and `ps_in`=00.
- Simultaneous load and branch:
  - Stimulus: old IR has off6=+2, `pc_r`=16'h0008, `il_in`=1 with `mem_rdata_in`=16'hBEEF, `ps_in`=10.
  - Response: `pc_out`=16'h000A, `ins_out`=16'hBEEF, `ins_pc_out`=16'h0008.
- Reset mid-execute:
  - Stimulus: after 3 fetches (`fetch_cnt_out`=3) and `pc_r`=16'h0042, assert `rst_n`=0 for one edge together with `ps_in`=11 and `il_in`=1.
  - Response: `pc_out`=RESET_PC, `ins_out`=0, `fetch_cnt_out`=0. The jump and the load are both ignored.

Source files
------------

// File: rtl/pc_ir.sv
// Program-counter / instruction-register stage: holds PC and IR, muxes the memory
// address, applies hold/increment/branch/jump, and tracks fetch count and IR address.
module pc_ir #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ps_in,
  input  logic        il_in,
  input  logic        mm_in,
  input  logic [15:0] mem_rdata_in,
  input  logic [15:0] reg_a_in,
  output logic [15:0] addr_out,
  output logic [15:0] ins_out,
  output logic [15:0] pc_out,
  output logic [15:0] ins_pc_out,
  output logic [15:0] fetch_cnt_out
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ins_pc_q, ins_pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  off6;
  logic [15:0] off_sext;

  // Branch offset is split across the IR around the register field in [5:3].
  assign off6     = {ir_q[8:6], ir_q[2:0]};
  assign off_sext = {{10{off6[5]}}, off6};

  always_comb begin
    pc_d = pc_q;
    case (ps_in)
      2'b01:   pc_d = pc_q + 16'd1;
      2'b10:   pc_d = pc_q + off_sext;
      2'b11:   pc_d = reg_a_in;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    ir_d     = ir_q;
    ins_pc_d = ins_pc_q;
    cnt_d    = cnt_q;
    if (il_in) begin
      ir_d     = mem_rdata_in;
      ins_pc_d = pc_q;
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      ins_pc_q <= RESET_PC;
      cnt_q    <= 16'h0000;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ins_pc_q <= ins_pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign addr_out      = mm_in ? pc_q : reg_a_in;
  assign ins_out       = ir_q;
  assign pc_out        = pc_q;
  assign ins_pc_out    = ins_pc_q;
  assign fetch_cnt_out = cnt_q;

endmodule
